// File: rtl/sng_pkg.sv
// Shared types and constants for the multi-channel stochastic number generator.
// The LFSR tap table is consulted only when the build defines SNG_LFSR_EN.
package sng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Fibonacci feedback masks (bit i = tap at stage i+1), maximal length for W = 2..12.
    localparam logic [11:0] LFSR_TAPS [0:12] = '{
        12'h000, 12'h000, 12'h003, 12'h006, 12'h00C, 12'h014, 12'h030,
        12'h060, 12'h0B8, 12'h110, 12'h240, 12'h500, 12'h829
    };

endpackage

// File: rtl/sng_sel_dec.sv
// Trailing-ones decoder: maps the stream counter to the operand bit to emit.
// One instance is shared by every channel.
module sng_sel_dec
    import sng_pkg::*;
#(
    parameter int W     = 4,
    parameter int SEL_W = 2
) (
    input  logic [W-1:0]     cnt,
    output logic [SEL_W-1:0] sel,
    output logic             all_ones
);

    int  ones;
    logic run;

    always_comb begin
        ones = 0;
        run  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (run && cnt[i]) begin
                ones = ones + 1;
            end else begin
                run = 1'b0;
            end
        end
        // Bit k of the operand is picked 2^k times per stream, so ones add up exactly.
        sel      = SEL_W'(W - 1 - ones);
        all_ones = &cnt;
    end

endmodule

// File: rtl/sng_multi.sv
// N_CH-channel stochastic bit-stream generator (ramp select, optional LFSR compare).
// Define SNG_LFSR_EN to add the i_mode input and the LFSR comparison mode.
module sng_multi
    import sng_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int W         = 4,
    parameter int LFSR_SEED = 1
) (
    input  logic                     i_clk_sng,
    input  logic                     i_rst_sng,
    input  logic [N_CH-1:0][W-1:0]   i_x,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_en,
`ifdef SNG_LFSR_EN
    input  logic                     i_mode,
`endif
    output logic                     o_valid,
    output logic [N_CH-1:0]          o_sn_bit,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int SEL_W = $clog2(W);

    state_t                 state, state_nx;
    logic [W-1:0]           cnt;
    logic [N_CH-1:0][W-1:0] x_r;
    logic                   done_r;
    logic                   gen_end;
    logic [SEL_W-1:0]       sel;
    logic                   all_ones;
    logic                   accept;

`ifdef SNG_LFSR_EN
    localparam logic [W-1:0] TAPS = W'(LFSR_TAPS[W]);
    logic [W-1:0] lfsr;
    logic         mode_r;
`endif

    sng_sel_dec #(
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel_dec (
        .cnt      (cnt),
        .sel      (sel),
        .all_ones (all_ones)
    );

    assign accept  = (state == IDLE) && i_start;
    assign o_valid = (state == GEN) && i_en;
    assign o_busy  = (state == GEN);
    assign o_done  = done_r;

    always_comb begin
        state_nx = state;
        gen_end  = 1'b0;
        case (state)
            IDLE: if (i_start) state_nx = GEN;
            GEN: begin
                if (i_stop || (i_en && all_ones)) begin
                    state_nx = IDLE;
                    gen_end  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            state  <= IDLE;
            cnt    <= '0;
            x_r    <= '0;
            done_r <= 1'b0;
`ifdef SNG_LFSR_EN
            lfsr   <= W'(LFSR_SEED);
            mode_r <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            done_r <= gen_end;
            if (accept) begin
                x_r    <= i_x;
                cnt    <= '0;
`ifdef SNG_LFSR_EN
                lfsr   <= W'(LFSR_SEED);
                mode_r <= i_mode;
`endif
            end else if (o_valid) begin
                cnt    <= cnt + 1'b1;
`ifdef SNG_LFSR_EN
                lfsr   <= {lfsr[W-2:0], ^(lfsr & TAPS)};
`endif
            end
        end
    end

    // Final counter value emits zero so each channel totals exactly x ones.
    always_comb begin
        o_sn_bit = '0;
        for (int c = 0; c < N_CH; c++) begin
`ifdef SNG_LFSR_EN
            if (mode_r) begin
                o_sn_bit[c] = o_valid && !all_ones && (lfsr <= x_r[c]);
            end else begin
                o_sn_bit[c] = o_valid && !all_ones && x_r[c][sel];
            end
`else
            o_sn_bit[c] = o_valid && !all_ones && x_r[c][sel];
`endif
        end
    end

endmodule

// File: tb/tb_sng_multi.sv
// Scoreboard bench for sng_multi: per-cycle expectations queued by the driver, checked by a monitor.
module tb_sng_multi;

    localparam int N_CH = 4;
    localparam int W    = 4;
    localparam int L    = 16;

    typedef struct packed {
        logic       v;
        logic [3:0] b;
        logic [3:0] care;
        logic       busy;
        logic       done;
        logic [7:0] id;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_CH-1:0][W-1:0] x   = '0;
    logic                   start = 1'b0;
    logic                   stop  = 1'b0;
    logic                   en    = 1'b1;
`ifdef SNG_LFSR_EN
    logic                   mode  = 1'b0;
`endif
    logic                   valid;
    logic [N_CH-1:0]        sn_bit;
    logic                   busy;
    logic                   done;

    int total = 0;
    int bad   = 0;
    int ones [N_CH];
    int vcnt;
    logic [7:0] cur_id = 8'd0;
    logic [N_CH-1:0][W-1:0] xs;
    int sel_tbl [16] = '{3, 2, 3, 1, 3, 2, 3, 0, 3, 2, 3, 1, 3, 2, 3, 0};
    exp_t q[$];

    sng_multi #(.N_CH(N_CH), .W(W), .LFSR_SEED(1)) dut (
        .i_clk_sng (clk),
        .i_rst_sng (rst),
        .i_x       (x),
        .i_start   (start),
        .i_stop    (stop),
        .i_en      (en),
`ifdef SNG_LFSR_EN
        .i_mode    (mode),
`endif
        .o_valid   (valid),
        .o_sn_bit  (sn_bit),
        .o_busy    (busy),
        .o_done    (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (valid !== e.v || busy !== e.busy || done !== e.done ||
                $isunknown(sn_bit) || (((sn_bit ^ e.b) & e.care) != 4'h0)) begin
                bad++;
                $display("FAIL cycle(test %0d): valid/busy/done/bits got %b/%b/%b/%b want %b/%b/%b/%b care %b",
                         e.id, valid, busy, done, sn_bit, e.v, e.busy, e.done, e.b, e.care);
            end
            if (valid === 1'b1) begin
                vcnt++;
                for (int c = 0; c < N_CH; c++) ones[c] += int'(sn_bit[c]);
            end
        end
    end

    function automatic logic [3:0] ramp_bits(input int k);
        logic [3:0] b;
        for (int c = 0; c < N_CH; c++) b[c] = (k == L - 1) ? 1'b0 : xs[c][sel_tbl[k]];
        return b;
    endfunction

    task automatic step(input logic v, input logic [3:0] b, input logic [3:0] care,
                        input logic bz, input logic dn);
        exp_t e;
        e = '{v: v, b: b, care: care, busy: bz, done: dn, id: cur_id};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic dn);
        step(1'b0, 4'h0, 4'hF, 1'b0, dn);
    endtask

    task automatic gen(input int k, input logic on);
        if (on) step(1'b1, ramp_bits(k), 4'hF, 1'b1, 1'b0);
        else    step(1'b0, 4'h0, 4'hF, 1'b1, 1'b0);
    endtask

    task automatic begin_stream(input logic [N_CH-1:0][W-1:0] vec);
        x  = vec;
        xs = vec;
        for (int c = 0; c < N_CH; c++) ones[c] = 0;
        vcnt  = 0;
        start = 1'b1;
        idle(1'b0);
        start = 1'b0;
    endtask

    task automatic check_ones();
        for (int c = 0; c < N_CH; c++) begin
            total++;
            if (ones[c] != int'(xs[c])) begin
                bad++;
                $display("FAIL ones(test %0d ch %0d): got %0d want %0d", cur_id, c, ones[c], xs[c]);
            end
        end
    endtask

    task automatic check_vcnt(input int want);
        total++;
        if (vcnt != want) begin
            bad++;
            $display("FAIL valid_count(test %0d): got %0d want %0d", cur_id, vcnt, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        idle(1'b0);

        // Full ramp stream, x = {0,5,10,15}
        cur_id = 8'd1;
        begin_stream({4'd15, 4'd10, 4'd5, 4'd0});
        for (int k = 0; k < L; k++) gen(k, 1'b1);
        idle(1'b1);
        idle(1'b0);
        check_ones();
        check_vcnt(16);

        // Full ramp stream, channel 0 x = 8 gives 1,0,1,0,... with last bit 0
        cur_id = 8'd2;
        begin_stream({4'd7, 4'd1, 4'd3, 4'd8});
        for (int k = 0; k < L; k++) gen(k, 1'b1);
        idle(1'b1);
        idle(1'b0);
        check_ones();

        // Abort on the 6th valid cycle
        cur_id = 8'd3;
        begin_stream({4'd15, 4'd10, 4'd5, 4'd0});
        for (int k = 0; k < 5; k++) gen(k, 1'b1);
        stop = 1'b1;
        gen(5, 1'b1);
        stop = 1'b0;
        idle(1'b1);
        idle(1'b0);
        check_vcnt(6);

        // Start with stop also high in IDLE, then a 3-cycle stall mid-stream
        cur_id = 8'd4;
        stop = 1'b1;
        begin_stream({4'd7, 4'd1, 4'd3, 4'd8});
        stop = 1'b0;
        for (int k = 0; k < 5; k++) gen(k, 1'b1);
        en = 1'b0;
        for (int s = 0; s < 3; s++) gen(5, 1'b0);
        en = 1'b1;
        for (int k = 5; k < L; k++) gen(k, 1'b1);
        idle(1'b1);
        idle(1'b0);
        check_ones();
        check_vcnt(16);

        // Start and operand changes during GEN are ignored; reset at cycle 7 abandons the stream
        cur_id = 8'd5;
        begin_stream({4'd7, 4'd1, 4'd3, 4'd8});
        gen(0, 1'b1);
        gen(1, 1'b1);
        start = 1'b1;
        x = {4'd0, 4'd15, 4'd9, 4'd6};
        for (int k = 2; k < 7; k++) gen(k, 1'b1);
        start = 1'b0;
        rst = 1'b1;
        step(1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1'b0);
        stop = 1'b1;
        idle(1'b0);
        idle(1'b0);
        stop = 1'b0;
        idle(1'b0);

`ifdef SNG_LFSR_EN
        // LFSR mode: exact one-counts, last bit 0
        cur_id = 8'd6;
        mode = 1'b1;
        begin_stream({4'd0, 4'd15, 4'd1, 4'd11});
        mode = 1'b0;
        for (int k = 0; k < L - 1; k++) step(1'b1, 4'h0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'h0, 4'hF, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        check_ones();
`endif

        idle(1'b0);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
